cf_fft_stage_seq: RTL and testbench

CF_FFT_STAGE_SEQ -- requirements
Module: cf_fft_stage_seq

---
 rtl/cf_fft_pkg.sv | 26 ++
 rtl/cf_fft_addr_delay.sv | 61 ++++++
 rtl/cf_fft_stage_seq.sv | 196 +++++++++++++++++++
 tb/tb_cf_fft_stage_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cf_fft_pkg.sv
// Shared types and default sizing for the FFT stage sequencer.
package cf_fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } cf_state_e;

    localparam int CF_LOG2N_DEF = 10;
    localparam int CF_LAT_DEF   = 4;

    // Width of the butterfly issue counter: it counts 0 .. N/2-1.
    localparam int CF_KW_DEF = CF_LOG2N_DEF - 1;

    function automatic int cf_kw(input int log2n);
        return log2n - 1;
    endfunction

    // Width of the stage index port; never narrower than one bit.
    function automatic int cf_sw(input int log2n);
        return (log2n > 1) ? $clog2(log2n) : 1;
    endfunction

endpackage

// File: rtl/cf_fft_addr_delay.sv
// Enable-gated LAT-deep delay line carrying {issue_valid, rd_addr_a, rd_addr_b}
// so write-back addresses line up with butterfly results.
module cf_fft_addr_delay
    import cf_fft_pkg::*;
#(
    parameter int AW  = CF_LOG2N_DEF,
    parameter int LAT = CF_LAT_DEF
) (
    input  logic          clock_c,
    input  logic          reset,
    input  logic          en,
    input  logic          in_valid,
    input  logic [AW-1:0] in_a,
    input  logic [AW-1:0] in_b,
    output logic          out_valid,
    output logic [AW-1:0] out_a,
    output logic [AW-1:0] out_b
);

    logic [LAT-1:0]         v_q = '0;
    logic [LAT-1:0]         v_d;
    logic [LAT-1:0][AW-1:0] a_q = '0;
    logic [LAT-1:0][AW-1:0] a_d;
    logic [LAT-1:0][AW-1:0] b_q = '0;
    logic [LAT-1:0][AW-1:0] b_d;

    // Shift one slot per enabled cycle; hold everything while the pipe is frozen.
    always_comb begin
        v_d = v_q;
        a_d = a_q;
        b_d = b_q;
        if (en) begin
            v_d[0] = in_valid;
            a_d[0] = in_a;
            b_d[0] = in_b;
            for (int i = 1; i < LAT; i++) begin
                v_d[i] = v_q[i-1];
                a_d[i] = a_q[i-1];
                b_d[i] = b_q[i-1];
            end
        end
    end

    // Delay-line registers with synchronous clear.
    always_ff @(posedge clock_c) begin
        if (reset) begin
            v_q <= '0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            v_q <= v_d;
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign out_valid = v_q[LAT-1];
    assign out_a     = a_q[LAT-1];
    assign out_b     = b_q[LAT-1];

endmodule

// File: rtl/cf_fft_stage_seq.sv
// Radix-2 FFT stage sequencer: walks the N/2 butterflies of one stage,
// generates operand/twiddle addresses and the delayed write-back addresses.
//
// state | meaning
// IDLE  | waiting for start; bad stage index pulses err
// RUN   | issuing one butterfly per enabled cycle, k = 0 .. N/2-1
// DRAIN | flushing the LAT-deep butterfly pipeline
// DONE  | one-cycle done pulse, then back to IDLE
module cf_fft_stage_seq
    import cf_fft_pkg::*;
#(
    parameter int LOG2N = CF_LOG2N_DEF,
    parameter int LAT   = CF_LAT_DEF
) (
    input  logic                    clock_c,
    input  logic                    reset,
    input  logic                    start,
    input  logic [cf_sw(LOG2N)-1:0] stage,
    input  logic                    stall,
    output logic [LOG2N-1:0]        rd_addr_a,
    output logic [LOG2N-1:0]        rd_addr_b,
    output logic [LOG2N-2:0]        tw_addr,
    output logic                    bf_en,
    output logic [LOG2N-1:0]        wr_addr_a,
    output logic [LOG2N-1:0]        wr_addr_b,
    output logic                    wr_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int AW = LOG2N;
    localparam int KW = cf_kw(LOG2N);
    localparam int SW = cf_sw(LOG2N);
    localparam int CW = $clog2(LAT + 1);

    localparam logic [SW:0]   S_LIMIT    = (SW+1)'(LOG2N);
    localparam logic [SW:0]   TW_TOP     = (SW+1)'(KW);
    localparam logic [KW-1:0] K_LAST     = '1;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(LAT);

    cf_state_e     state_q = ST_IDLE;
    cf_state_e     state_d;
    logic [KW-1:0] k_q = '0;
    logic [KW-1:0] k_d;
    logic [SW-1:0] s_q = '0;
    logic [SW-1:0] s_d;
    logic [CW-1:0] cnt_q = '0;
    logic [CW-1:0] cnt_d;
    logic          err_q = 1'b0;
    logic          err_d;

    logic          en;
    logic          issue_valid;
    logic [AW-1:0] step;
    logic [AW-1:0] k_ext;
    logic [AW-1:0] pos;
    logic [AW-1:0] grp;
    logic [AW-1:0] issue_a;
    logic [AW-1:0] issue_b;
    logic [KW-1:0] issue_tw;
    logic [AW-1:0] dly_in_a;
    logic [AW-1:0] dly_in_b;
    logic          dly_valid;
    logic [AW-1:0] dly_a;
    logic [AW-1:0] dly_b;

    // Butterfly address generation: insert a zero bit at position s of k.
    always_comb begin
        step     = AW'(1) << s_q;
        k_ext    = AW'(k_q);
        pos      = k_ext & (step - AW'(1));
        grp      = k_ext >> s_q;
        issue_a  = (grp << ({1'b0, s_q} + 1'b1)) | pos;
        issue_b  = issue_a + step;
        issue_tw = KW'(pos << (TW_TOP - {1'b0, s_q}));
    end

    // Next-state, counter and issue-enable logic.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        s_d         = s_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        en          = 1'b0;
        issue_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ({1'b0, stage} < S_LIMIT) begin
                        state_d = ST_RUN;
                        k_d     = '0;
                        s_d     = stage;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    en          = 1'b1;
                    issue_valid = 1'b1;
                    if (k_q == K_LAST) begin
                        state_d = ST_DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!stall) begin
                    en    = 1'b1;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers with synchronous clear.
    always_ff @(posedge clock_c) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Drained slots carry zero addresses so the pipe never holds stale pairs.
    always_comb begin
        dly_in_a = issue_valid ? issue_a : '0;
        dly_in_b = issue_valid ? issue_b : '0;
    end

    cf_fft_addr_delay #(
        .AW  (AW),
        .LAT (LAT)
    ) u_addr_delay (
        .clock_c   (clock_c),
        .reset     (reset),
        .en        (en),
        .in_valid  (issue_valid),
        .in_a      (dly_in_a),
        .in_b      (dly_in_b),
        .out_valid (dly_valid),
        .out_a     (dly_a),
        .out_b     (dly_b)
    );

    // Output drive; reset forces every output low in the same cycle.
    always_comb begin
        rd_addr_a = '0;
        rd_addr_b = '0;
        tw_addr   = '0;
        bf_en     = 1'b0;
        wr_addr_a = '0;
        wr_addr_b = '0;
        wr_valid  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        if (!reset) begin
            if (state_q == ST_RUN) begin
                rd_addr_a = issue_a;
                rd_addr_b = issue_b;
                tw_addr   = issue_tw;
            end
            bf_en     = en;
            wr_addr_a = dly_a;
            wr_addr_b = dly_b;
            wr_valid  = en & dly_valid;
            busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
            done      = (state_q == ST_DONE);
            err       = err_q;
        end
    end

endmodule

// File: tb/tb_cf_fft_stage_seq.sv
// Self-checking bench for cf_fft_stage_seq at LOG2N=3, LAT=4.
module tb_cf_fft_stage_seq;

    localparam int LOG2N = 3;
    localparam int LAT   = 4;
    localparam int H     = 1 << (LOG2N - 1);

    logic       clock_c = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] stage;
    logic       stall;
    logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [1:0] tw_addr;
    logic       bf_en, wr_valid, busy, done, err;

    cf_fft_stage_seq #(.LOG2N(LOG2N), .LAT(LAT)) dut (
        .clock_c   (clock_c),
        .reset     (reset),
        .start     (start),
        .stage     (stage),
        .stall     (stall),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .bf_en     (bf_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .wr_valid  (wr_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clock_c = ~clock_c;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Butterfly k of stage s: operand a is k with a zero inserted at bit s.
    function automatic int pa(input int s, input int k);
        int lo, hi;
        lo = k % (1 << s);
        hi = k / (1 << s);
        return hi * (2 << s) + lo;
    endfunction

    function automatic int ptw(input int s, input int k);
        return (k % (1 << s)) * (1 << (LOG2N - 1 - s));
    endfunction

    // Model: a stage is a run of H+LAT enabled cycles after an accepted start,
    // then one done cycle. m_e counts enabled cycles already spent.
    int cyc      = 0;
    int m_phase  = 0;
    int m_e      = 0;
    int m_s      = 0;
    int m_err    = 0;
    int stage_id = 0;

    always @(posedge clock_c) begin
        cyc++;
        if (reset) begin
            m_phase = 0;
            m_e     = 0;
            m_err   = 0;
        end else begin
            m_err = 0;
            case (m_phase)
                0: if (start) begin
                    if (int'(stage) < LOG2N) begin
                        m_phase = 1;
                        m_e     = 0;
                        m_s     = int'(stage);
                        stage_id++;
                    end else begin
                        m_err = 1;
                    end
                end
                1: if (!stall) begin
                    m_e++;
                    if (m_e == H + LAT) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    int issue_q[$];
    int wr_q[$];
    int done_cnt      = 0;
    int err_cnt       = 0;
    int bfen_cnt      = 0;
    int busy_cnt      = 0;
    int last_done_cyc = -1;
    int wr_in_stage   = 0;
    int seen_id       = 0;

    // Per-cycle compare of every output against the model, plus event logging.
    always @(negedge clock_c) begin
        int ea, eb, etw, ebf, ewv, ebusy, edone, eerr;
        ea = 0; eb = 0; etw = 0; ebf = 0; ewv = 0; ebusy = 0; edone = 0; eerr = 0;
        if (seen_id != stage_id) begin
            seen_id     = stage_id;
            wr_in_stage = 0;
        end
        if (!reset) begin
            eerr  = m_err;
            ebusy = (m_phase == 1) ? 1 : 0;
            edone = (m_phase == 2) ? 1 : 0;
            if (m_phase == 1) begin
                ebf = stall ? 0 : 1;
                if (m_e < H) begin
                    ea  = pa(m_s, m_e);
                    eb  = ea + (1 << m_s);
                    etw = ptw(m_s, m_e);
                end
                ewv = (ebf == 1 && m_e >= LAT) ? 1 : 0;
            end
        end
        chk("rd_addr_a", int'(rd_addr_a), ea);
        chk("rd_addr_b", int'(rd_addr_b), eb);
        chk("tw_addr", int'(tw_addr), etw);
        chk("bf_en", int'(bf_en), ebf);
        chk("wr_valid", int'(wr_valid), ewv);
        chk("busy", int'(busy), ebusy);
        chk("done", int'(done), edone);
        chk("err", int'(err), eerr);
        if (ewv == 1) begin
            chk("wr_addr_a", int'(wr_addr_a), pa(m_s, m_e - LAT));
            chk("wr_addr_b", int'(wr_addr_b), pa(m_s, m_e - LAT) + (1 << m_s));
        end
        if (edone == 1) chk("wr_per_stage", wr_in_stage, H);

        if (bf_en && m_phase == 1 && m_e < H)
            issue_q.push_back((int'(rd_addr_a) << 8) | (int'(rd_addr_b) << 4) | int'(tw_addr));
        if (wr_valid) begin
            wr_q.push_back((int'(wr_addr_a) << 4) | int'(wr_addr_b));
            wr_in_stage++;
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (err)   err_cnt++;
        if (bf_en) bfen_cnt++;
        if (busy)  busy_cnt++;
    end

    task automatic tick();
        @(posedge clock_c);
        #1;
    endtask

    task automatic chk_issue(input string nm, input int i0,
                             input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        chk({nm, "_count"}, issue_q.size() - i0, 4);
        for (int j = 0; j < 4; j++)
            if (i0 + j < issue_q.size()) chk(nm, issue_q[i0 + j], e[j]);
    endtask

    task automatic chk_wr(input string nm, input int w0, input int n,
                          input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        chk({nm, "_count"}, wr_q.size() - w0, n);
        for (int j = 0; j < n; j++)
            if (w0 + j < wr_q.size()) chk(nm, wr_q[w0 + j], e[j]);
    endtask

    // Runs one stage with per-cycle stall/start masks (bit c = cycle c after start).
    task automatic run_stage(input int s, input logic [63:0] stall_m,
                             input logic [63:0] start_m, output int lat);
        int c0;
        bit seen;
        c0    = cyc;
        start = 1'b1;
        stage = 2'(s);
        stall = stall_m[0];
        seen  = 1'b0;
        lat   = -1;
        for (int c = 1; c < 64; c++) begin
            tick();
            start = start_m[c];
            stall = stall_m[c];
            if (!seen && last_done_cyc > c0) begin
                seen = 1'b1;
                lat  = last_done_cyc - c0;
            end
            if (seen && cyc >= last_done_cyc + 3) break;
        end
        start = 1'b0;
        stall = 1'b0;
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, i0, w0, d0, e0, b0, y0;
        reset = 1'b1;
        start = 1'b0;
        stage = 2'd0;
        stall = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // s=0, no stall
        i0 = issue_q.size(); w0 = wr_q.size(); d0 = done_cnt;
        run_stage(0, 64'h0, 64'h0, lat);
        chk_issue("s0_issue", i0, 'h010, 'h230, 'h450, 'h670);
        chk_wr("s0_wr", w0, 4, 'h01, 'h23, 'h45, 'h67);
        chk("s0_done_latency", lat, 9);
        chk("s0_done_count", done_cnt - d0, 1);

        // s=1
        i0 = issue_q.size(); w0 = wr_q.size();
        run_stage(1, 64'h0, 64'h0, lat);
        chk_issue("s1_issue", i0, 'h020, 'h132, 'h460, 'h572);
        chk_wr("s1_wr", w0, 4, 'h02, 'h13, 'h46, 'h57);
        chk("s1_done_latency", lat, 9);

        // s=2, stalled on 2nd issue for 3 cycles and for 3 cycles in DRAIN
        i0 = issue_q.size(); w0 = wr_q.size();
        run_stage(2, 64'hE1C, 64'h0, lat);
        chk_issue("s2_issue", i0, 'h040, 'h151, 'h262, 'h373);
        chk_wr("s2_wr", w0, 4, 'h04, 'h15, 'h26, 'h37);
        chk("s2_done_latency", lat, 15);

        // start re-pulsed mid-RUN and in the DONE cycle
        w0 = wr_q.size(); d0 = done_cnt;
        run_stage(0, 64'h0, 64'h204, lat);
        chk("restart_wr_count", wr_q.size() - w0, 4);
        chk("restart_done_count", done_cnt - d0, 1);
        chk("restart_done_latency", lat, 9);
        repeat (3) tick();
        chk("restart_no_extra_done", done_cnt - d0, 1);

        // invalid stage index
        e0 = err_cnt; b0 = bfen_cnt; y0 = busy_cnt;
        start = 1'b1; stage = 2'd3;
        tick();
        start = 1'b0; stage = 2'd0;
        repeat (4) tick();
        chk("bad_stage_err_pulses", err_cnt - e0, 1);
        chk("bad_stage_bf_en", bfen_cnt - b0, 0);
        chk("bad_stage_busy", busy_cnt - y0, 0);

        // reset in DRAIN with two results still in flight
        w0 = wr_q.size();
        start = 1'b1; stage = 2'd0;
        tick();
        start = 1'b0;
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock_c);
        chk("post_reset_busy", int'(busy), 0);
        chk("post_reset_wr_valid", int'(wr_valid), 0);
        chk_wr("reset_wr", w0, 2, 'h01, 'h23, 0, 0);
        tick();
        i0 = issue_q.size(); w0 = wr_q.size();
        run_stage(0, 64'h0, 64'h0, lat);
        chk_issue("after_reset_issue", i0, 'h010, 'h230, 'h450, 'h670);
        chk_wr("after_reset_wr", w0, 4, 'h01, 'h23, 'h45, 'h67);
        chk("after_reset_latency", lat, 9);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 5) == 0);
            stage = 2'($urandom_range(0, 3));
            stall = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 120) == 0);
            tick();
        end
        reset = 1'b0; start = 1'b0; stall = 1'b0;
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
